// File: rtl/fetch_unit.sv
// AXI4 instruction-fetch front end: issues INCR bursts from a running fetch PC, splits each
// beat into 32-bit instructions and streams them from a FIFO tagged with PC and fault flag.
module fetch_unit #(
    parameter int ID_WIDTH   = 13,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int BURST_LEN  = 8,
    parameter int FIFO_DEPTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] entry,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [ID_WIDTH-1:0]   m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [31:0]           inst,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    output logic                  inst_fault
);

    localparam int SLOTS       = DATA_WIDTH / 32;
    localparam int BEAT_BYTES  = DATA_WIDTH / 8;
    localparam int BURST_BYTES = BURST_LEN * BEAT_BYTES;
    localparam int BURST_SLOTS = BURST_LEN * SLOTS;
    localparam int PTR_W       = $clog2(FIFO_DEPTH);
    localparam int CNT_W       = PTR_W + 1;
    localparam logic [ADDR_WIDTH-1:0] BURST_MASK = ADDR_WIDTH'(BURST_BYTES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DRAIN} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
    logic [ADDR_WIDTH-1:0]   beat_addr_q, beat_addr_d;
    logic                    drain_pend_q, drain_pend_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;

    logic [31:0]             mem_inst_q  [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]   mem_pc_q    [FIFO_DEPTH];
    logic                    mem_fault_q [FIFO_DEPTH];

    logic                    beat_fire;
    logic                    push_en;
    logic                    pop;
    logic                    beat_fault;
    logic [CNT_W-1:0]        free_cnt;
    logic [CNT_W-1:0]        push_cnt;
    logic [ADDR_WIDTH-1:0]   slot_addr [SLOTS];
    logic [SLOTS-1:0]        slot_keep;
    logic [PTR_W-1:0]        slot_ofs  [SLOTS];
    logic                    unused_rid;

    assign unused_rid    = ^m_axi_rid;

    assign m_axi_arid    = '0;
    assign m_axi_arlen   = 8'(BURST_LEN - 1);
    assign m_axi_arsize  = 3'($clog2(BEAT_BYTES));
    assign m_axi_arburst = 2'b01;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'b0000;
    assign m_axi_arprot  = 3'b110;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arvalid = (state_q == S_ADDR);
    assign m_axi_rready  = (state_q == S_DATA) || (state_q == S_DRAIN);

    assign beat_fire  = m_axi_rvalid && m_axi_rready;
    assign push_en    = (state_q == S_DATA) && beat_fire && !redirect_valid;
    assign beat_fault = |m_axi_rresp;
    assign free_cnt   = CNT_W'(FIFO_DEPTH) - count_q;

    assign inst_valid = (count_q != '0);
    assign pop        = inst_valid && inst_ready && !redirect_valid;
    assign inst       = mem_inst_q[rd_ptr_q];
    assign inst_pc    = mem_pc_q[rd_ptr_q];
    assign inst_fault = mem_fault_q[rd_ptr_q];

    // Slots below the fetch PC belong to a mid-burst entry point and are dropped.
    generate
        for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
            assign slot_addr[gi] = beat_addr_q + ADDR_WIDTH'(4 * gi);
            assign slot_keep[gi] = push_en && (slot_addr[gi] >= pc_q);
        end
    endgenerate

    // Kept slots are packed contiguously into the FIFO, low slot first.
    always_comb begin
        push_cnt = '0;
        for (int k = 0; k < SLOTS; k++) begin
            slot_ofs[k] = push_cnt[PTR_W-1:0];
            if (slot_keep[k]) begin
                push_cnt = push_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < SLOTS; k++) begin
            if (slot_keep[k]) begin
                mem_inst_q[wr_ptr_q + slot_ofs[k]]  <= m_axi_rdata[32*k +: 32];
                mem_pc_q[wr_ptr_q + slot_ofs[k]]    <= slot_addr[k];
                mem_fault_q[wr_ptr_q + slot_ofs[k]] <= beat_fault;
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (redirect_valid) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + push_cnt[PTR_W-1:0];
            rd_ptr_d = rd_ptr_q + PTR_W'(pop);
            count_d  = count_q + push_cnt - CNT_W'(pop);
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        araddr_d     = araddr_q;
        beat_addr_d  = beat_addr_q;
        drain_pend_d = drain_pend_q;
        if (beat_fire) begin
            beat_addr_d = beat_addr_q + ADDR_WIDTH'(BEAT_BYTES);
        end
        case (state_q)
            S_IDLE: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                end else if (free_cnt >= CNT_W'(BURST_SLOTS)) begin
                    araddr_d    = pc_q & ~BURST_MASK;
                    beat_addr_d = pc_q & ~BURST_MASK;
                    state_d     = S_ADDR;
                end
            end
            S_ADDR: begin
                // The address phase cannot be withdrawn; a redirect turns the burst into a drain.
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                end
                if (m_axi_arready) begin
                    state_d      = (redirect_valid || drain_pend_q) ? S_DRAIN : S_DATA;
                    drain_pend_d = 1'b0;
                end else if (redirect_valid) begin
                    drain_pend_d = 1'b1;
                end
            end
            S_DATA: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    state_d = (beat_fire && m_axi_rlast) ? S_IDLE : S_DRAIN;
                end else if (beat_fire && m_axi_rlast) begin
                    pc_d    = araddr_q + ADDR_WIDTH'(BURST_BYTES);
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                end
                if (beat_fire && m_axi_rlast) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            pc_q         <= entry;
            araddr_q     <= '0;
            beat_addr_q  <= '0;
            drain_pend_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            araddr_q     <= araddr_d;
            beat_addr_q  <= beat_addr_d;
            drain_pend_q <= drain_pend_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a small AXI read slave, a consumer monitor and
// hand-computed expectations for burst issue, slot skipping, back-pressure, redirect and faults.
module tb_fetch_unit;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int IW = 13;
    localparam int BL = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [AW-1:0] entry = 64'h1000;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic [IW-1:0] m_axi_arid;
    logic [AW-1:0] m_axi_araddr;
    logic [7:0]    m_axi_arlen;
    logic [2:0]    m_axi_arsize;
    logic [1:0]    m_axi_arburst;
    logic          m_axi_arlock;
    logic [3:0]    m_axi_arcache;
    logic [2:0]    m_axi_arprot;
    logic          m_axi_arvalid;
    logic          m_axi_arready = 1'b0;
    logic [IW-1:0] m_axi_rid = '0;
    logic [DW-1:0] m_axi_rdata = '0;
    logic [1:0]    m_axi_rresp = 2'b00;
    logic          m_axi_rlast = 1'b0;
    logic          m_axi_rvalid = 1'b0;
    logic          m_axi_rready;
    logic          inst_valid;
    logic          inst_ready = 1'b1;
    logic [31:0]   inst;
    logic [AW-1:0] inst_pc;
    logic          inst_fault;

    fetch_unit #(
        .ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL), .FIFO_DEPTH(32)
    ) dut (
        .clk(clk), .reset(reset), .entry(entry),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
        .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready), .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata),
        .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .inst_pc(inst_pc), .inst_fault(inst_fault)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    int          beats_left = 0;
    int          cur_beat = 0;
    int          beats_total = 0;
    int          fault_beat = -1;
    logic        arready_en = 1'b1;
    logic [63:0] ar_q[$];
    int          ar_pops_q[$];
    int          ar_beats_q[$];
    logic [63:0] pop_pc_q[$];
    logic [31:0] pop_inst_q[$];
    logic        pop_fault_q[$];
    int          pop_total = 0;
    int          first_beat_cyc = -1;
    int          first_valid_cyc = -1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_pops(input int n, input string tag);
        int t = 0;
        while (pop_pc_q.size() < n && t < 2000) begin
            step();
            t++;
        end
        check(tag, 64'(pop_pc_q.size() >= n), 64'd1);
    endtask

    task automatic wait_ars(input int n, input string tag);
        int t = 0;
        while (ar_q.size() < n && t < 2000) begin
            step();
            t++;
        end
        check(tag, 64'(ar_q.size() >= n), 64'd1);
    endtask

    task automatic do_reset(input logic [63:0] e);
        reset = 1'b0;
        entry = e;
        redirect_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        ar_q.delete();
        ar_pops_q.delete();
        ar_beats_q.delete();
        pop_pc_q.delete();
        pop_inst_q.delete();
        pop_fault_q.delete();
        pop_total = 0;
        beats_total = 0;
        first_beat_cyc = -1;
        first_valid_cyc = -1;
        reset = 1'b1;
    endtask

    // AXI read slave: handshakes are sampled at the falling edge, responses updated just after the rising edge.
    initial begin : axi_slave
        logic        ar_hs;
        logic        r_hs;
        logic [63:0] ar_addr_s;
        forever begin
            @(negedge clk);
            ar_hs     = m_axi_arvalid && m_axi_arready;
            r_hs      = m_axi_rvalid && m_axi_rready;
            ar_addr_s = m_axi_araddr;
            @(posedge clk);
            #1;
            if (!reset) begin
                beats_left = 0;
                cur_beat   = 0;
            end else begin
                if (r_hs) begin
                    beats_left--;
                    cur_beat++;
                    beats_total++;
                end
                if (ar_hs) begin
                    $display("AR  addr=%0h pops=%0d beats=%0d", ar_addr_s, pop_total, beats_total);
                    ar_q.push_back(ar_addr_s);
                    ar_pops_q.push_back(pop_total);
                    ar_beats_q.push_back(beats_total);
                    beats_left = BL;
                    cur_beat   = 0;
                end
            end
            m_axi_arready = arready_en;
            m_axi_rvalid  = (beats_left > 0);
            m_axi_rdata   = {32'(2 * cur_beat + 1), 32'(2 * cur_beat)};
            m_axi_rlast   = (cur_beat == BL - 1);
            m_axi_rresp   = (cur_beat == fault_beat && ar_q.size() == 1) ? 2'b10 : 2'b00;
        end
    end

    initial begin : consumer_monitor
        forever begin
            @(negedge clk);
            if (reset) begin
                if (first_beat_cyc < 0 && m_axi_rvalid && m_axi_rready) first_beat_cyc = cyc;
                if (first_valid_cyc < 0 && inst_valid) first_valid_cyc = cyc;
                if (inst_valid && inst_ready && !redirect_valid) begin
                    $display("POP pc=%0h inst=%0h fault=%0b", inst_pc, inst, inst_fault);
                    pop_pc_q.push_back(inst_pc);
                    pop_inst_q.push_back(inst);
                    pop_fault_q.push_back(inst_fault);
                    pop_total++;
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int n15;
        int mark;
        int t;

        // Reset state while reset is held low
        repeat (2) @(posedge clk);
        #2;
        check("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
        check("rst_rready", 64'(m_axi_rready), 64'd0);
        check("rst_inst_valid", 64'(inst_valid), 64'd0);
        check("rst_araddr", m_axi_araddr, 64'h0);

        // Aligned entry, free-running consumer
        arready_en = 1'b1;
        inst_ready = 1'b1;
        do_reset(64'h1000);
        wait_pops(16, "t1_wait_pops");
        check("t1_araddr0", ar_q[0], 64'h1000);
        check("t1_arlen", 64'(m_axi_arlen), 64'd7);
        check("t1_arsize", 64'(m_axi_arsize), 64'd3);
        check("t1_arburst", 64'(m_axi_arburst), 64'd1);
        check("t1_arid", 64'(m_axi_arid), 64'd0);
        check("t1_arprot", 64'(m_axi_arprot), 64'd6);
        check("t1_arcache", 64'(m_axi_arcache), 64'd0);
        check("t1_arlock", 64'(m_axi_arlock), 64'd0);
        check("t1_latency", 64'(first_valid_cyc - first_beat_cyc), 64'd1);
        for (int i = 0; i < 16; i++) begin
            check("t1_inst", 64'(pop_inst_q[i]), 64'(i));
            check("t1_pc", pop_pc_q[i], 64'h1000 + 64'(4 * i));
        end
        wait_ars(2, "t1_wait_ar2");
        check("t1_araddr1", ar_q[1], 64'h1040);

        // Mid-burst entry: slot 0x1040 is dropped
        do_reset(64'h1044);
        wait_pops(20, "t2_wait_pops");
        check("t2_araddr0", ar_q[0], 64'h1040);
        check("t2_first_pc", pop_pc_q[0], 64'h1044);
        check("t2_first_inst", 64'(pop_inst_q[0]), 64'd1);
        n15 = 0;
        for (int i = 0; i < pop_pc_q.size(); i++) begin
            if (pop_pc_q[i] < 64'h1080) n15++;
        end
        check("t2_first_burst_count", 64'(n15), 64'd15);

        // Consumer stalled: two bursts fill the FIFO, third waits for 16 pops
        inst_ready = 1'b0;
        do_reset(64'h1000);
        repeat (150) step();
        check("t3_ar_count", 64'(ar_q.size()), 64'd2);
        check("t3_valid", 64'(inst_valid), 64'd1);
        check("t3_pc_a", inst_pc, 64'h1000);
        check("t3_inst_a", 64'(inst), 64'd0);
        repeat (5) step();
        check("t3_pc_b", inst_pc, 64'h1000);
        check("t3_inst_b", 64'(inst), 64'd0);
        inst_ready = 1'b1;
        wait_ars(3, "t3_wait_ar3");
        check("t3_pops_before_ar3", 64'(ar_pops_q[2] >= 16), 64'd1);
        check("t3_araddr2", ar_q[2], 64'h1080);

        // Redirect on the third R beat of the first burst
        do_reset(64'h1000);
        t = 0;
        while (!(m_axi_rvalid && m_axi_rready && cur_beat == 2 && ar_q.size() == 1) && t < 200) begin
            step();
            t++;
        end
        check("t4_found_beat2", 64'(t < 200), 64'd1);
        redirect_pc = 64'h2000;
        redirect_valid = 1'b1;
        mark = pop_total;
        step();
        redirect_valid = 1'b0;
        check("t4_flushed", 64'(inst_valid), 64'd0);
        wait_pops(mark + 16, "t4_wait_pops");
        check("t4_araddr1", ar_q[1], 64'h2000);
        check("t4_drained_beats", 64'(ar_beats_q[1]), 64'd8);
        for (int j = 0; j < 16; j++) begin
            check("t4_pc", pop_pc_q[mark + j], 64'h2000 + 64'(4 * j));
            check("t4_inst", 64'(pop_inst_q[mark + j]), 64'(j));
        end

        // Redirect while the address phase is stalled
        arready_en = 1'b0;
        do_reset(64'h1000);
        t = 0;
        while (!m_axi_arvalid && t < 50) begin
            step();
            t++;
        end
        check("t5_found_arvalid", 64'(m_axi_arvalid), 64'd1);
        redirect_pc = 64'h3000;
        redirect_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            check("t5_araddr_hold", m_axi_araddr, 64'h1000);
            check("t5_arvalid_hold", 64'(m_axi_arvalid), 64'd1);
            step();
            redirect_valid = 1'b0;
        end
        arready_en = 1'b1;
        wait_ars(2, "t5_wait_ar2");
        check("t5_araddr0", ar_q[0], 64'h1000);
        check("t5_araddr1", ar_q[1], 64'h3000);
        check("t5_drained_beats", 64'(ar_beats_q[1]), 64'd8);
        wait_pops(4, "t5_wait_pops");
        check("t5_pc0", pop_pc_q[0], 64'h3000);
        check("t5_pc3", pop_pc_q[3], 64'h300C);

        // Error response on beat 2 marks instructions 4 and 5
        fault_beat = 2;
        do_reset(64'h1000);
        wait_pops(16, "t6_wait_pops");
        for (int i = 0; i < 16; i++) begin
            check("t6_fault", 64'(pop_fault_q[i]), 64'(i == 4 || i == 5));
        end
        fault_beat = -1;

        // Asynchronous reset in the middle of a burst
        t = 0;
        while (!(m_axi_rready && m_axi_rvalid && cur_beat == 3) && t < 200) begin
            step();
            t++;
        end
        check("t7_mid_burst", 64'(m_axi_rready), 64'd1);
        #1;
        reset = 1'b0;
        #1;
        check("t7_arvalid", 64'(m_axi_arvalid), 64'd0);
        check("t7_rready", 64'(m_axi_rready), 64'd0);
        check("t7_inst_valid", 64'(inst_valid), 64'd0);
        check("t7_araddr", m_axi_araddr, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
